mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 255, cycles a grant may wait for ext_ack_i before abort (used only with MEM_ARBITER_TIMEOUT_EN).
REQ-002 clk_i  in  1  single clock; all state changes on its rising edge.
REQ-003 rst_i  in  1  asynchronous, active-low reset.
REQ-004 if_req_i  in  1  IF-stage instruction fetch request, held until if_ack_o.
REQ-005 if_addr_i  in  32  fetch address.
REQ-006 if_data_o  out  32  fetched instruction, valid while if_ack_o=1.
REQ-007 if_ack_o  out  1  one-cycle fetch completion pulse.
REQ-008 mem_req_i  in  1  MEM-stage load/store request, held until mem_ack_o.
REQ-009 mem_we_i  in  1  1=store, 0=load.
REQ-010 mem_addr_i  in  32  data address.
REQ-011 mem_wdata_i  in  32  store data.
REQ-012 mem_rdata_o  out  32  load data, valid while mem_ack_o=1.
REQ-013 mem_ack_o  out  1  one-cycle data completion pulse.
REQ-014 ext_req_o / ext_we_o  out  1/1  shared memory port request / write enable.
REQ-015 ext_addr_o / ext_wdata_o  out  32/32  shared port address / write data.
REQ-016 ext_rdata_i / ext_ack_i  in  32/1  shared port read data / completion.
REQ-017 stall_o  out  1  freeze PC, IF/ID and upstream pipeline registers.
REQ-018 err_o  out  1  sticky timeout flag.

Function
REQ-019 FSM states SHALL be IDLE, GRANT_IF, GRANT_MEM, RESP.
REQ-020 IDLE: mem_req_i=1 -> GRANT_MEM; else if_req_i=1 -> GRANT_IF; else stay (MEM fixed priority, older instruction first).
REQ-021 On entering a GRANT state the block SHALL register the winner's address, we and wdata; IF grants force ext_we_o=0.
REQ-022 ext_req_o SHALL be 1 exactly while in GRANT_IF/GRANT_MEM, with ext_addr_o/ext_we_o/ext_wdata_o stable throughout.
REQ-023 GRANT state with ext_ack_i=1 at a rising edge -> RESP, capturing ext_rdata_i into the winner's data register.
REQ-024 RESP SHALL assert exactly the winner's ack for one cycle, then return to IDLE unconditionally.
REQ-025 Minimum latency: req sampled in IDLE at edge N, ext_req_o=1 after N, ext_ack_i at edge N+1, ack_o=1 in cycle after N+1 (3 cycles req-to-ack).
REQ-026 On a store, mem_rdata_o SHALL hold its previous value; mem_ack_o still pulses.
REQ-027 if_data_o/mem_rdata_o SHALL hold their last captured values between transactions.
REQ-028 ext_ack_i SHALL be ignored in IDLE and RESP.
REQ-029 A request deasserted mid-grant SHALL NOT abort the transaction; the ack still pulses.
REQ-030 stall_o SHALL equal (if_req_i & ~if_ack_o) | (mem_req_i & ~mem_ack_o), combinational.
REQ-031 Both requests arriving in the same IDLE cycle: MEM served first, IF served on the next IDLE visit (no requests dropped).

Reset
REQ-032 rst_i=0 SHALL immediately force state IDLE, ext_req_o=0, ext_we_o=0, ext_addr_o=0, ext_wdata_o=0, if_ack_o=0, mem_ack_o=0, if_data_o=0, mem_rdata_o=0, err_o=0, timeout counter=0.
REQ-033 Reset mid-grant SHALL abandon the transaction with no ack issued; pending requests re-arbitrate after release.

Configuration
REQ-034 With MEM_ARBITER_TIMEOUT_EN defined, a counter SHALL count GRANT cycles; reaching TIMEOUT_CYCLES without ext_ack_i -> RESP with captured data 32'hDEADBEEF and err_o set sticky until reset.
REQ-035 Without MEM_ARBITER_TIMEOUT_EN, grants SHALL wait indefinitely and err_o SHALL be constant 0.

Verification
REQ-036 Single load: mem_req_i=1, mem_addr_i=0x40, ext_ack_i one cycle after ext_req_o with ext_rdata_i=0x12345678 -> mem_ack_o pulse, mem_rdata_o=0x12345678, 3-cycle latency.
REQ-037 Simultaneous if_req_i and mem_req_i (store 0xA5A5A5A5 to 0x80) -> ext_we_o=1, ext_addr_o=0x80 first; then IF read; stall_o high until each ack.
REQ-038 ext_ack_i delayed 10 cycles -> ext_req_o and address stable all 10 cycles, stall_o=1 throughout, single ack pulse.
REQ-039 Reset asserted during GRANT_MEM -> all outputs zero immediately, no ack; after release with mem_req_i held, transaction reissued.
REQ-040 MEM_ARBITER_TIMEOUT_EN, TIMEOUT_CYCLES=4, ext_ack_i never asserted -> ack after 4 grant cycles, data 0xDEADBEEF, err_o=1 until reset; without macro, no ack and err_o=0.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Shared external memory port between the arbiter and the memory.
//   master : arbiter side. It drives the request, write enable, address and
//            write data, and receives the read data and completion.
//   slave  : memory side. It uses the same signals with the directions reversed.
// The signal names match the arbiter's view of the port (_o = arbiter output).
interface mem_arbiter_if;
   logic        ext_req_o;
   logic        ext_we_o;
   logic [31:0] ext_addr_o;
   logic [31:0] ext_wdata_o;
   logic [31:0] ext_rdata_i;
   logic        ext_ack_i;

   modport master (
      output ext_req_o, ext_we_o, ext_addr_o, ext_wdata_o,
      input  ext_rdata_i, ext_ack_i
   );

   modport slave (
      input  ext_req_o, ext_we_o, ext_addr_o, ext_wdata_o,
      output ext_rdata_i, ext_ack_i
   );
endinterface

// File: rtl/mem_arbiter.sv
// Two-master arbiter for one shared memory port. The masters are the
// instruction fetch (IF) and the load/store (MEM) stages. MEM has fixed
// priority, and each grant runs to completion before the next arbitration.
//
// Optional feature macro: MEM_ARBITER_TIMEOUT_EN. When it is defined, a grant
// that waits TIMEOUT_CYCLES without ext_ack_i completes with data 32'hDEADBEEF
// and sets the sticky err_o flag.
//
// Ports
//   clk_i, rst_i               clock and async active-low reset
//   if_req_i/if_addr_i         fetch request and address
//   if_data_o/if_ack_o         fetch data and completion pulse
//   mem_req_i/we/addr/wdata    load/store request
//   mem_rdata_o/mem_ack_o      load data and completion pulse
//   ext                        shared memory port (mem_arbiter_if.master)
//   stall_o                    pipeline freeze while a request is outstanding
//   err_o                      sticky timeout flag
//
// state        | meaning
// -------------+----------------------------------------------
// ST_IDLE      | no grant; arbitrate (MEM before IF)
// ST_GRANT_IF  | ext port owned by fetch, waiting for ext_ack_i
// ST_GRANT_MEM | ext port owned by load/store, waiting for ext_ack_i
// ST_RESP      | one-cycle ack to the winner, then back to idle
module mem_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          if_req_i,
   input  logic [31:0]   if_addr_i,
   output logic [31:0]   if_data_o,
   output logic          if_ack_o,
   input  logic          mem_req_i,
   input  logic          mem_we_i,
   input  logic [31:0]   mem_addr_i,
   input  logic [31:0]   mem_wdata_i,
   output logic [31:0]   mem_rdata_o,
   output logic          mem_ack_o,
   mem_arbiter_if.master ext,
   output logic          stall_o,
   output logic          err_o
);

   localparam logic [1:0] ST_IDLE      = 2'd0;
   localparam logic [1:0] ST_GRANT_IF  = 2'd1;
   localparam logic [1:0] ST_GRANT_MEM = 2'd2;
   localparam logic [1:0] ST_RESP      = 2'd3;

   logic [1:0]  state_q, state_d;
   logic        we_q, we_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic        if_ack_q, if_ack_d;
   logic        mem_ack_q, mem_ack_d;
   logic [31:0] if_data_q, if_data_d;
   logic [31:0] mem_rdata_q, mem_rdata_d;
   logic        in_grant;
   logic        grant_done;
   logic [31:0] rsp_data;

   assign in_grant = (state_q == ST_GRANT_IF) || (state_q == ST_GRANT_MEM);

`ifdef MEM_ARBITER_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] tmo_cnt_q;
   logic             tmo_hit;
   logic             err_q;

   // The down-counter is loaded on grant entry. It reaches zero on the last
   // grant cycle allowed, and a real ack in that same cycle still takes priority.
   assign tmo_hit    = in_grant && !ext.ext_ack_i && (tmo_cnt_q == '0);
   assign grant_done = ext.ext_ack_i || tmo_hit;
   assign rsp_data   = ext.ext_ack_i ? ext.ext_rdata_i : 32'hDEADBEEF;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         tmo_cnt_q <= '0;
         err_q     <= 1'b0;
      end else begin
         if (state_q == ST_IDLE && state_d != ST_IDLE) begin
            tmo_cnt_q <= CNT_LOAD;
         end else if (in_grant && tmo_cnt_q != '0) begin
            tmo_cnt_q <= tmo_cnt_q - 1'b1;
         end
         if (tmo_hit) begin
            err_q <= 1'b1;
         end
      end
   end

   assign err_o = err_q;
`else
   assign grant_done = ext.ext_ack_i;
   assign rsp_data   = ext.ext_rdata_i;
   assign err_o      = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      we_d        = we_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      if_ack_d    = 1'b0;
      mem_ack_d   = 1'b0;
      if_data_d   = if_data_q;
      mem_rdata_d = mem_rdata_q;
      unique case (state_q)
         ST_IDLE: begin
            if (mem_req_i) begin
               state_d = ST_GRANT_MEM;
               we_d    = mem_we_i;
               addr_d  = mem_addr_i;
               wdata_d = mem_wdata_i;
            end else if (if_req_i) begin
               state_d = ST_GRANT_IF;
               we_d    = 1'b0;
               addr_d  = if_addr_i;
               wdata_d = 32'd0;
            end
         end
         ST_GRANT_IF: begin
            if (grant_done) begin
               state_d   = ST_RESP;
               if_ack_d  = 1'b1;
               if_data_d = rsp_data;
            end
         end
         ST_GRANT_MEM: begin
            if (grant_done) begin
               state_d   = ST_RESP;
               mem_ack_d = 1'b1;
               // A store returns no data, so the last load value stays in the register.
               if (!we_q) begin
                  mem_rdata_d = rsp_data;
               end
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q     <= ST_IDLE;
         we_q        <= 1'b0;
         addr_q      <= 32'd0;
         wdata_q     <= 32'd0;
         if_ack_q    <= 1'b0;
         mem_ack_q   <= 1'b0;
         if_data_q   <= 32'd0;
         mem_rdata_q <= 32'd0;
      end else begin
         state_q     <= state_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         if_ack_q    <= if_ack_d;
         mem_ack_q   <= mem_ack_d;
         if_data_q   <= if_data_d;
         mem_rdata_q <= mem_rdata_d;
      end
   end

   assign ext.ext_req_o   = in_grant;
   assign ext.ext_we_o    = we_q;
   assign ext.ext_addr_o  = addr_q;
   assign ext.ext_wdata_o = wdata_q;

   assign if_ack_o    = if_ack_q;
   assign mem_ack_o   = mem_ack_q;
   assign if_data_o   = if_data_q;
   assign mem_rdata_o = mem_rdata_q;

   assign stall_o = (if_req_i & ~if_ack_o) | (mem_req_i & ~mem_ack_o);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter. A table of single transactions is applied in a loop.
// Each request pushes its expected completion to a queue, and the queue is
// popped when an ack pulse appears. Hand-written sequences then cover
// simultaneous requests, ack in idle, a request dropped mid-grant, reset
// mid-grant and timeout behaviour.
module tb_mem_arbiter;

   localparam int TB_TMO = 4;
`ifdef MEM_ARBITER_TIMEOUT_EN
   localparam int MAX_DELAY = TB_TMO - 1;
`else
   localparam int MAX_DELAY = 1000;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        if_req = 1'b0;
   logic [31:0] if_addr = '0;
   logic [31:0] if_data;
   logic        if_ack;
   logic        mem_req = 1'b0;
   logic        mem_we = 1'b0;
   logic [31:0] mem_addr = '0;
   logic [31:0] mem_wdata = '0;
   logic [31:0] mem_rdata;
   logic        mem_ack;
   logic        stall;
   logic        err;

   always #5 clk = ~clk;

   mem_arbiter_if bus();

   mem_arbiter #(.TIMEOUT_CYCLES(TB_TMO)) dut (
      .clk_i      (clk),
      .rst_i      (rst_n),
      .if_req_i   (if_req),
      .if_addr_i  (if_addr),
      .if_data_o  (if_data),
      .if_ack_o   (if_ack),
      .mem_req_i  (mem_req),
      .mem_we_i   (mem_we),
      .mem_addr_i (mem_addr),
      .mem_wdata_i(mem_wdata),
      .mem_rdata_o(mem_rdata),
      .mem_ack_o  (mem_ack),
      .ext        (bus.master),
      .stall_o    (stall),
      .err_o      (err)
   );

   typedef struct {
      logic        is_mem;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          delay;
      logic        exp_we;
      logic [31:0] exp_data;
   } vec_t;

   typedef struct {
      logic        is_mem;
      logic [31:0] data;
   } exp_t;

   exp_t        sb[$];
   vec_t        vecs[7];
   int          n_vec = 0;
   int          n_miss = 0;
   logic [31:0] last_if = '0;
   logic [31:0] last_mem = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic wait_grant(input int limit, output int waited);
      waited = 0;
      while (bus.ext_req_o !== 1'b1 && waited < limit) begin
         @(negedge clk);
         waited++;
      end
   endtask

   // Called in the cycle where an ack pulse is expected.
   task automatic check_ack(input string name);
      exp_t e;
      n_vec++;
      if (sb.size() == 0) begin
         n_miss++;
         $display("FAIL %s: ack with empty scoreboard, got if_ack=%b mem_ack=%b", name, if_ack, mem_ack);
         return;
      end
      n_vec--;
      e = sb.pop_front();
      chk({name, " if_ack"}, 32'(if_ack), 32'(!e.is_mem));
      chk({name, " mem_ack"}, 32'(mem_ack), 32'(e.is_mem));
      if (e.is_mem) begin
         chk({name, " mem_rdata"}, mem_rdata, e.data);
         chk({name, " if_data held"}, if_data, last_if);
         last_mem = e.data;
      end else begin
         chk({name, " if_data"}, if_data, e.data);
         chk({name, " mem_rdata held"}, mem_rdata, last_mem);
         last_if = e.data;
      end
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int    w;
      string tag;
      tag = $sformatf("vec%0d", idx);
      @(negedge clk);
      if (v.is_mem) begin
         mem_req = 1'b1; mem_we = v.we; mem_addr = v.addr; mem_wdata = v.wdata;
      end else begin
         if_req = 1'b1; if_addr = v.addr;
         mem_we = 1'b1; mem_addr = 32'hFFFF_FFFC; mem_wdata = 32'h5555_5555;
      end
      sb.push_back('{v.is_mem, v.exp_data});
      wait_grant(20, w);
      chk({tag, " grant latency"}, 32'(w), 32'd1);
      chk({tag, " ext_addr"}, bus.ext_addr_o, v.addr);
      chk({tag, " ext_we"}, 32'(bus.ext_we_o), 32'(v.exp_we));
      if (v.is_mem) chk({tag, " ext_wdata"}, bus.ext_wdata_o, v.wdata);
      chk({tag, " stall"}, 32'(stall), 32'd1);
      for (int d = 0; d < v.delay; d++) begin
         @(negedge clk);
         chk({tag, " hold req"}, 32'(bus.ext_req_o), 32'd1);
         chk({tag, " hold addr"}, bus.ext_addr_o, v.addr);
         chk({tag, " hold stall"}, 32'(stall), 32'd1);
         chk({tag, " no early ack"}, 32'({if_ack, mem_ack}), 32'd0);
      end
      bus.ext_rdata_i = v.rdata;
      bus.ext_ack_i   = 1'b1;
      @(negedge clk);
      bus.ext_ack_i   = 1'b0;
      bus.ext_rdata_i = 32'h0BAD_F00D;
      chk({tag, " req low in resp"}, 32'(bus.ext_req_o), 32'd0);
      check_ack(tag);
      chk({tag, " stall at ack"}, 32'(stall), 32'd0);
      if_req = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
      @(negedge clk);
      chk({tag, " single pulse"}, 32'({if_ack, mem_ack}), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      bus.ext_ack_i   = 1'b0;
      bus.ext_rdata_i = '0;

      vecs[0] = '{1'b1, 1'b0, 32'h0000_0040, 32'h0,         32'h1234_5678, 0,  1'b0, 32'h1234_5678};
      vecs[1] = '{1'b0, 1'b0, 32'h0000_1000, 32'h0,         32'h0000_0013, 0,  1'b0, 32'h0000_0013};
      vecs[2] = '{1'b1, 1'b1, 32'h0000_0044, 32'hCAFE_F00D, 32'hFFFF_0000, 1,  1'b1, 32'h1234_5678};
      vecs[3] = '{1'b0, 1'b0, 32'h0000_1004, 32'h0,         32'h0051_0113, 10, 1'b0, 32'h0051_0113};
      vecs[4] = '{1'b1, 1'b0, 32'h0000_0048, 32'h0,         32'h8765_4321, 2,  1'b0, 32'h8765_4321};
      vecs[5] = '{1'b1, 1'b1, 32'h0000_004C, 32'h0000_0001, 32'hAAAA_5555, 0,  1'b1, 32'h8765_4321};
      vecs[6] = '{1'b0, 1'b0, 32'h0000_1008, 32'h0,         32'hFFFF_FFFF, 3,  1'b0, 32'hFFFF_FFFF};

      // Values held in reset
      #3;
      chk("rst ext_req", 32'(bus.ext_req_o), 32'd0);
      chk("rst ext_we", 32'(bus.ext_we_o), 32'd0);
      chk("rst ext_addr", bus.ext_addr_o, 32'd0);
      chk("rst ext_wdata", bus.ext_wdata_o, 32'd0);
      chk("rst acks", 32'({if_ack, mem_ack}), 32'd0);
      chk("rst if_data", if_data, 32'd0);
      chk("rst mem_rdata", mem_rdata, 32'd0);
      chk("rst err", 32'(err), 32'd0);
      chk("rst stall", 32'(stall), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         if (vecs[i].delay <= MAX_DELAY) run_vec(vecs[i], i);
      end

      // Both requests in the same idle cycle: store first, then fetch
      @(negedge clk);
      mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h80; mem_wdata = 32'hA5A5_A5A5;
      if_req = 1'b1; if_addr = 32'h200;
      sb.push_back('{1'b1, last_mem});
      sb.push_back('{1'b0, 32'h0000_0093});
      wait_grant(20, w);
      chk("simul mem first", 32'(w), 32'd1);
      chk("simul mem we", 32'(bus.ext_we_o), 32'd1);
      chk("simul mem addr", bus.ext_addr_o, 32'h80);
      chk("simul mem wdata", bus.ext_wdata_o, 32'hA5A5_A5A5);
      chk("simul stall 1", 32'(stall), 32'd1);
      bus.ext_ack_i = 1'b1; bus.ext_rdata_i = 32'h55;
      @(negedge clk);
      bus.ext_ack_i = 1'b0;
      check_ack("simul mem");
      chk("simul stall if pending", 32'(stall), 32'd1);
      mem_req = 1'b0; mem_we = 1'b0;
      wait_grant(20, w);
      chk("simul if regrant", 32'(w), 32'd2);
      chk("simul if addr", bus.ext_addr_o, 32'h200);
      chk("simul if we", 32'(bus.ext_we_o), 32'd0);
      chk("simul stall 2", 32'(stall), 32'd1);
      bus.ext_ack_i = 1'b1; bus.ext_rdata_i = 32'h93;
      @(negedge clk);
      bus.ext_ack_i = 1'b0;
      check_ack("simul if");
      chk("simul stall end", 32'(stall), 32'd0);
      if_req = 1'b0;
      @(negedge clk);

      // ext_ack_i in idle has no effect
      bus.ext_ack_i = 1'b1; bus.ext_rdata_i = 32'hDEAD_0001;
      @(negedge clk);
      bus.ext_ack_i = 1'b0;
      chk("idle ack req", 32'(bus.ext_req_o), 32'd0);
      chk("idle ack acks", 32'({if_ack, mem_ack}), 32'd0);
      chk("idle ack if_data", if_data, last_if);
      chk("idle ack mem_rdata", mem_rdata, last_mem);

      // Request dropped mid-grant still completes
      @(negedge clk);
      mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h60;
      sb.push_back('{1'b1, 32'h0000_600D});
      wait_grant(20, w);
      mem_req = 1'b0;
      @(negedge clk);
      chk("drop keeps grant", 32'(bus.ext_req_o), 32'd1);
      bus.ext_ack_i = 1'b1; bus.ext_rdata_i = 32'h600D;
      @(negedge clk);
      bus.ext_ack_i = 1'b0;
      check_ack("drop");
      @(negedge clk);

      // Reset during a store grant abandons it; the held request is reissued
      mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h70; mem_wdata = 32'h1234;
      wait_grant(20, w);
      chk("pre-rst grant", 32'(bus.ext_req_o), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst ext_req", 32'(bus.ext_req_o), 32'd0);
      chk("midrst ext_we", 32'(bus.ext_we_o), 32'd0);
      chk("midrst ext_addr", bus.ext_addr_o, 32'd0);
      chk("midrst ext_wdata", bus.ext_wdata_o, 32'd0);
      chk("midrst if_data", if_data, 32'd0);
      chk("midrst mem_rdata", mem_rdata, 32'd0);
      @(negedge clk);
      chk("midrst no ack", 32'({if_ack, mem_ack}), 32'd0);
      rst_n = 1'b1;
      last_if = '0; last_mem = '0;
      sb.push_back('{1'b1, 32'd0});
      wait_grant(20, w);
      chk("reissue latency", 32'(w), 32'd1);
      chk("reissue addr", bus.ext_addr_o, 32'h70);
      chk("reissue we", 32'(bus.ext_we_o), 32'd1);
      bus.ext_ack_i = 1'b1; bus.ext_rdata_i = 32'h7777;
      @(negedge clk);
      bus.ext_ack_i = 1'b0;
      check_ack("reissue");
      mem_req = 1'b0; mem_we = 1'b0;
      @(negedge clk);

      // Grant that never sees ext_ack_i
      mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h90;
      wait_grant(20, w);
`ifdef MEM_ARBITER_TIMEOUT_EN
      sb.push_back('{1'b1, 32'hDEAD_BEEF});
      for (int i = 0; i < TB_TMO - 1; i++) begin
         @(negedge clk);
         chk("tmo waiting req", 32'(bus.ext_req_o), 32'd1);
         chk("tmo waiting ack", 32'(mem_ack), 32'd0);
      end
      @(negedge clk);
      check_ack("tmo");
      chk("tmo err set", 32'(err), 32'd1);
      mem_req = 1'b0;
      repeat (3) @(negedge clk);
      chk("tmo err sticky", 32'(err), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("tmo err cleared", 32'(err), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
`else
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("no-tmo no ack", 32'(mem_ack), 32'd0);
         chk("no-tmo err", 32'(err), 32'd0);
      end
      chk("no-tmo still granted", 32'(bus.ext_req_o), 32'd1);
      mem_req = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
`endif
      @(negedge clk);
      n_vec++;
      if (sb.size() != 0) begin
         n_miss++;
         $display("FAIL scoreboard drain: got %0d entries expected 0", sb.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
